// File: rtl/uart_rx_cmd_fifo_pkg.sv
// Shared definitions for the UART command receiver: FSM encoding,
// oversampling constants and the baud divider computation.
package uart_rx_cmd_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam int OVS_TICKS  = 16;
   localparam int HALF_TICKS = 8;

   // Clocks per oversampling tick (integer division, truncating)
   function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
      return clk_freq / (baud * ovs);
   endfunction

endpackage

// File: rtl/cmd_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// A push is accepted when not full or when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored.
module cmd_sync_fifo #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              empty,
   output logic              full,
   output logic              drop
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign empty = (count_r == {(ADDR_W + 1){1'b0}});
   assign full  = (count_r == DEPTH_CNT);
   assign rdata = empty ? {DATA_W{1'b0}} : mem[rd_ptr_r];

   // Decide which of the requested operations actually take effect
   always_comb begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
      drop      = 1'b0;
      if (push && (!full || pop)) begin
         push_ok_s = 1'b1;
      end else begin
         drop = push;
      end
      if (pop && !empty) begin
         pop_ok_s = 1'b1;
      end else begin
         pop_ok_s = 1'b0;
      end
   end

   // Storage write; contents need no reset because empty masks the head
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         rd_ptr_r <= {ADDR_W{1'b0}};
         count_r  <= {(ADDR_W + 1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{ADDR_W{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_cmd_fifo.sv
// 8N1 UART receiver feeding a command FIFO. Good bytes are pushed one
// cycle after the stop-bit sample; framing errors and overflows pulse.
module uart_rx_cmd_fifo
   import uart_rx_cmd_fifo_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600,
   parameter int OVS      = OVS_TICKS,
   parameter int ADDR_W   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       i_fifo_pop,
   output logic       o_fifo_empty,
   output logic       o_fifo_full,
   output logic [7:0] o_fifo_rdata,
   output logic       o_rx_done,
   output logic       o_frame_err,
   output logic       o_overflow
);

   localparam int DIV    = calc_div(CLK_FREQ, BAUD, OVS);
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W = (OVS > 1) ? $clog2(OVS) : 1;
   localparam int HALF   = (OVS == OVS_TICKS) ? HALF_TICKS : OVS / 2;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] OVS_LAST  = TICK_W'(OVS - 1);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF - 1);

   rx_state_t         state_r;
   logic              rx_meta_r;
   logic              rx_s;
   logic [DIV_W-1:0]  div_cnt_r;
   logic              tick_s;
   logic [TICK_W-1:0] tick_cnt_r;
   logic [2:0]        bit_cnt_r;
   logic [7:0]        shift_r;
   logic              rx_done_r;
   logic              frame_err_r;

   assign tick_s      = (div_cnt_r == DIV_LAST);
   assign o_rx_done   = rx_done_r;
   assign o_frame_err = frame_err_r;

   // Two-stage synchronizer for the asynchronous RX pin, idling high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_r <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_s      <= rx_meta_r;
      end
   end

   // Oversampling divider, realigned to the start edge of every frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if ((state_r == ST_IDLE) && !rx_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (tick_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + {{(DIV_W - 1){1'b0}}, 1'b1};
      end
   end

   // Frame FSM: mid-bit sampling, LSB-first shift, stop-bit verdict pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         tick_cnt_r  <= {TICK_W{1'b0}};
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         rx_done_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         rx_done_r   <= 1'b0;
         frame_err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_r    <= ST_START;
                  tick_cnt_r <= {TICK_W{1'b0}};
               end
            end
            ST_START: begin
               if (tick_s) begin
                  if (tick_cnt_r == HALF_LAST) begin
                     tick_cnt_r <= {TICK_W{1'b0}};
                     bit_cnt_r  <= 3'd0;
                     state_r    <= rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + {{(TICK_W - 1){1'b0}}, 1'b1};
                  end
               end
            end
            ST_DATA: begin
               if (tick_s) begin
                  if (tick_cnt_r == OVS_LAST) begin
                     tick_cnt_r         <= {TICK_W{1'b0}};
                     shift_r[bit_cnt_r] <= rx_s;
                     if (bit_cnt_r == 3'd7) begin
                        state_r <= ST_STOP;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                     end
                  end else begin
                     tick_cnt_r <= tick_cnt_r + {{(TICK_W - 1){1'b0}}, 1'b1};
                  end
               end
            end
            ST_STOP: begin
               if (tick_s) begin
                  if (tick_cnt_r == OVS_LAST) begin
                     tick_cnt_r  <= {TICK_W{1'b0}};
                     rx_done_r   <= rx_s;
                     frame_err_r <= !rx_s;
                     state_r     <= ST_IDLE;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + {{(TICK_W - 1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   cmd_sync_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_done_r),
      .wdata (shift_r),
      .pop   (i_fifo_pop),
      .rdata (o_fifo_rdata),
      .empty (o_fifo_empty),
      .full  (o_fifo_full),
      .drop  (o_overflow)
   );

endmodule

// File: tb/tb_uart_rx_cmd_fifo.sv
// Directed bench for uart_rx_cmd_fifo with DIV=10 (160 clocks per bit).
module tb_uart_rx_cmd_fifo;

   localparam int BIT_CLKS = 160;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       i_fifo_pop;
   logic       o_fifo_empty;
   logic       o_fifo_full;
   logic [7:0] o_fifo_rdata;
   logic       o_rx_done;
   logic       o_frame_err;
   logic       o_overflow;

   int n_cmp;
   int n_bad;
   int done_cnt;
   int err_cnt;
   int ovf_cnt;
   int d0;
   int e0;
   int o0;
   int wait_cyc;

   uart_rx_cmd_fifo #(
      .CLK_FREQ (1_600_000),
      .BAUD     (10_000),
      .OVS      (16),
      .ADDR_W   (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .i_fifo_pop   (i_fifo_pop),
      .o_fifo_empty (o_fifo_empty),
      .o_fifo_full  (o_fifo_full),
      .o_fifo_rdata (o_fifo_rdata),
      .o_rx_done    (o_rx_done),
      .o_frame_err  (o_frame_err),
      .o_overflow   (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: counts values present during each completed cycle
   always @(posedge clk) begin
      if (o_rx_done)   done_cnt <= done_cnt + 1;
      if (o_frame_err) err_cnt  <= err_cnt + 1;
      if (o_overflow)  ovf_cnt  <= ovf_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_data_bits(input logic [7:0] d);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_v);
      send_data_bits(d);
      drive_bit(stop_v);
      rx = 1'b1;
   endtask

   task automatic wait_done();
      wait_cyc = 0;
      while (!o_rx_done && wait_cyc < 300) begin
         @(negedge clk);
         wait_cyc++;
      end
   endtask

   task automatic snap();
      d0 = done_cnt;
      e0 = err_cnt;
      o0 = ovf_cnt;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      chk(tag, o_fifo_rdata, exp);
      i_fifo_pop = 1'b1;
      @(negedge clk);
      i_fifo_pop = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      done_cnt = 0; err_cnt = 0; ovf_cnt = 0;
      rst = 1'b0; rx = 1'b1; i_fifo_pop = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_empty", o_fifo_empty, 1);
      chk("rst_full", o_fifo_full, 0);
      chk("rst_rdata", o_fifo_rdata, 8'h00);
      chk("rst_pulses", {o_rx_done, o_frame_err, o_overflow}, 3'b000);
      rst = 1'b1;
      repeat (20) @(negedge clk);

      // 1: good byte, FWFT latency, pop
      snap();
      send_data_bits(8'h52);
      rx = 1'b1;
      wait_done();
      chk("t1_done_seen", o_rx_done, 1);
      chk("t1_empty_at_T", o_fifo_empty, 1);
      @(negedge clk);
      chk("t1_empty_T1", o_fifo_empty, 0);
      chk("t1_rdata", o_fifo_rdata, 8'h52);
      chk("t1_done_one_cycle", o_rx_done, 0);
      repeat (100) @(negedge clk);
      chk("t1_done_cnt", done_cnt - d0, 1);
      chk("t1_err_cnt", err_cnt - e0, 0);
      i_fifo_pop = 1'b1;
      @(negedge clk);
      i_fifo_pop = 1'b0;
      chk("t1_empty_after_pop", o_fifo_empty, 1);
      chk("t1_rdata_empty", o_fifo_rdata, 8'h00);

      // 2: short low glitch
      snap();
      rx = 1'b0;
      repeat (60) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      chk("t2_done", done_cnt - d0, 0);
      chk("t2_err", err_cnt - e0, 0);
      chk("t2_empty", o_fifo_empty, 1);

      // 3: framing error, then a good byte
      snap();
      send_byte(8'hA5, 1'b0);
      repeat (320) @(negedge clk);
      chk("t3_err", err_cnt - e0, 1);
      chk("t3_done", done_cnt - d0, 0);
      chk("t3_empty", o_fifo_empty, 1);
      send_byte(8'h3C, 1'b1);
      repeat (20) @(negedge clk);
      chk("t3_done2", done_cnt - d0, 1);
      pop_expect("t3_rdata", 8'h3C);
      chk("t3_empty2", o_fifo_empty, 1);

      // 4: overflow on the fifth byte
      snap();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
      chk("t4_full4", o_fifo_full, 1);
      chk("t4_ovf4", ovf_cnt - o0, 0);
      send_byte(8'h05, 1'b1);
      repeat (20) @(negedge clk);
      chk("t4_ovf5", ovf_cnt - o0, 1);
      chk("t4_done5", done_cnt - d0, 5);
      chk("t4_full5", o_fifo_full, 1);
      pop_expect("t4_pop1", 8'h01);
      chk("t4_not_full", o_fifo_full, 0);
      pop_expect("t4_pop2", 8'h02);
      pop_expect("t4_pop3", 8'h03);
      pop_expect("t4_pop4", 8'h04);
      chk("t4_empty", o_fifo_empty, 1);

      // 5: pop in the same cycle as a push while full
      snap();
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
      chk("t5_full", o_fifo_full, 1);
      send_data_bits(8'h15);
      rx = 1'b1;
      wait_done();
      chk("t5_done_seen", o_rx_done, 1);
      i_fifo_pop = 1'b1;
      #1;
      chk("t5_no_ovf_now", o_overflow, 0);
      @(negedge clk);
      i_fifo_pop = 1'b0;
      chk("t5_full_kept", o_fifo_full, 1);
      repeat (100) @(negedge clk);
      chk("t5_ovf_cnt", ovf_cnt - o0, 0);
      pop_expect("t5_pop1", 8'h12);
      pop_expect("t5_pop2", 8'h13);
      pop_expect("t5_pop3", 8'h14);
      pop_expect("t5_pop4", 8'h15);
      chk("t5_empty", o_fifo_empty, 1);

      // 6: reset in the middle of a frame with two bytes buffered
      send_byte(8'h21, 1'b1);
      send_byte(8'h22, 1'b1);
      chk("t6_buffered", o_fifo_empty, 0);
      snap();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i));
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_empty_rst", o_fifo_empty, 1);
      chk("t6_full_rst", o_fifo_full, 0);
      chk("t6_rdata_rst", o_fifo_rdata, 8'h00);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (320) @(negedge clk);
      chk("t6_no_pulses", (done_cnt - d0) + (err_cnt - e0) + (ovf_cnt - o0), 0);
      send_byte(8'hC3, 1'b1);
      repeat (20) @(negedge clk);
      chk("t6_done", done_cnt - d0, 1);
      pop_expect("t6_rdata", 8'hC3);
      chk("t6_single_entry", o_fifo_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_cmd_fifo.md
Name: uart_rx_cmd_fifo

Overview:
UART receiver that deserializes 8N1 frames from the PC terminal and writes each good byte into a small command FIFO. It is the writer/producer end of the FIFO handshake that the watch/stopwatch mode control unit consumes through its empty flag and pop pulse. The head byte is presented first-word-fall-through. The block sits between the board RX pin and the mode control unit, alongside the button pulse path.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bits per second
OVS, 16, oversampling ticks per bit
ADDR_W, 2, FIFO address width; depth = 2**ADDR_W (4)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
rx  in  1  serial line; idles high
i_fifo_pop  in  1  one-cycle pop request from the consumer
o_fifo_empty  out  1  FIFO holds no bytes
o_fifo_full  out  1  FIFO holds 2**ADDR_W bytes
o_fifo_rdata  out  8  head byte; valid while o_fifo_empty=0
o_rx_done  out  1  one-cycle pulse when a good frame is received
o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low
o_overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: FSM=IDLE; all counters and pointers 0; o_fifo_empty=1, o_fifo_full=0, o_fifo_rdata=0x00. Pulse outputs are 0.
- Reset mid-frame: the partial byte is discarded and the FIFO is cleared.
- Input synchronizer: rx passes through a 2-FF synchronizer (rx_s) that resets to 1. All sampling uses rx_s.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVS), integer division (651 at defaults).
  - A one-cycle tick fires every DIV clocks.
  - The divider counter is cleared on entry to START so that ticks align with the frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s=0, go to START with tick_cnt=0.
  - START: on the 8th tick (mid start bit), sample rx_s. If it is 1, treat it as a glitch and return to IDLE with no output. If it is 0, go to DATA with bit_cnt=0 and tick_cnt=0.
  - DATA: every 16 ticks, sample rx_s into shift bit bit_cnt. Data is LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample rx_s. If it is 1, the byte is good: assert o_rx_done and request a push. If it is 0, assert o_frame_err and discard the byte. In both cases return to IDLE in the same cycle.
  - Returning to IDLE at mid-stop-bit is intentional; the next start edge is accepted immediately.
- FIFO:
  - Synchronous write and pointer-based read. count width is ADDR_W+1.
  - Push accepted when (!full || pop).
  - A good byte arriving while full with no pop is dropped. o_overflow pulses in the same cycle as o_rx_done, and the FIFO contents are unchanged.
  - Pop when empty is ignored.
  - Simultaneous push and pop: both are performed and count is unchanged, including at full and at count 1.
  - Simultaneous push and pop while empty: the push is performed and the pop is ignored.
  - Pointers wrap modulo 2**ADDR_W.
- Latency:
  - A stop sample at cycle T writes the FIFO at the T+1 edge. o_fifo_empty falls and o_fifo_rdata is valid from T+1.
  - A pop at cycle P advances the head. The new o_fifo_rdata and flags are visible from P+1.
- o_fifo_rdata outputs mem[rd_ptr] while the FIFO is non-empty and 0x00 when it is empty.

Decomposition:
- Shared package: the FSM state encoding (IDLE/START/DATA/STOP), the OVS and half-bit (8) constants, and the DIV computation function.
- One sub-module: cmd_sync_fifo (parameters ADDR_W and DATA_W=8; push, pop, rdata, empty, full).
- The receiver FSM, synchronizer and tick generator stay in the top module.

Test Plan:
All tests use CLK_FREQ=1_600_000 and BAUD=10_000, so DIV=10 and one bit = 160 clk.
1. Send 0x52 with a good stop bit -> exactly one o_rx_done pulse; o_fifo_empty=0 and o_fifo_rdata=0x52 one clk after the stop sample. Pulse i_fifo_pop -> o_fifo_empty=1 on the next clk.
2. Drive rx low for 60 clk, then high -> FSM returns to IDLE; no o_rx_done and no o_frame_err; the FIFO stays empty.
3. Send 0xA5 with the stop bit driven 0 -> one o_frame_err pulse; o_rx_done=0; o_fifo_empty stays 1. Then send 0x3C -> received correctly.
4. Send 0x01..0x05 back-to-back with no pop -> o_fifo_full=1 after the 4th byte; o_overflow pulses on the 5th. Four pops return 01, 02, 03, 04; o_fifo_empty=1 after the last.
5. Fill the FIFO with 0x11..0x14, then pulse i_fifo_pop exactly in the 0x15 push cycle -> no o_overflow; full stays 1. Subsequent pops return 12, 13, 14, 15.
6. Assert rst=0 mid-way through the data bits of 0x7E with 2 bytes buffered -> o_fifo_empty=1 immediately and no pulses. Release rst and send 0xC3 -> o_fifo_rdata=0xC3 and a single entry.
